conware_gen_ctrl: RTL and testbench
===================================

# conware_gen_ctrl

Generation sequencer for the Conway datapath. It captures one HEIGHT x WIDTH frame of cell states from the upstream row stream into an internal ping-pong frame store. It then runs a programmed number of generations by driving the external combinational shredder array one row per cycle, and streams the final frame downstream. It sits between the axis2buffer output (row states plus handshake) and the buffer2axis input, replacing their direct connection.

## Interface
- WIDTH, 32, cells per row; bit c = column c, 1 = alive.
- HEIGHT, 32, rows per frame (>= 1).
- GEN_W, 16, width of the generation count.
- RW, $clog2(HEIGHT) (min 1), row index width.

- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored unless idle.
- num_gens  in  GEN_W  generations to run; sampled when start is accepted.
- in_data  in  WIDTH  upstream row states.
- in_valid  in  1  upstream row valid.
- in_last  in  1  upstream end-of-frame marker.
- in_ready  out  1  row accepted when in_valid & in_ready.
- sh_above / sh_center / sh_below  out  WIDTH  row window to the shredder array.
- sh_next  in  WIDTH  next-generation center row from the shredder, same cycle.
- out_data  out  WIDTH  downstream row states.
- out_valid  out  1  downstream row valid.
- out_last  out  1  high with the row HEIGHT-1 beat.
- out_ready  in  1  downstream ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final row is accepted.
- gen_count  out  GEN_W  generations completed in the current run.
- err_framing  out  1  sticky framing error; cleared on accepted start.

## Operation
- Storage: two banks of HEIGHT x WIDTH registers; cur_bank selects the live frame.
- FSM states: IDLE, LOAD, COMPUTE, EMIT.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - On start: latch num_gens, row = 0, gen_count = 0, clear err_framing, go to LOAD.
- LOAD:
  - in_ready = 1. Each handshake writes in_data to cur_bank[row] and increments row.
  - Handshake on row HEIGHT-1: if in_last = 0, set err_framing. Then go to COMPUTE, or to EMIT if num_gens = 0. Row resets to 0 either way.
  - in_last on row r < HEIGHT-1: set err_framing and zero rows r+1..HEIGHT-1 of cur_bank on the same edge. Then proceed as if row HEIGHT-1 had arrived.
- COMPUTE, one row per cycle:
  - sh_center = cur[row], sh_above = cur[(row-1) mod HEIGHT], sh_below = cur[(row+1) mod HEIGHT]. Rows wrap toroidally; with HEIGHT = 1, all three are row 0.
  - sh_next is written to the other bank at [row].
  - At row HEIGHT-1: toggle cur_bank, increment gen_count, set row = 0.
  - If the new gen_count == num_gens, go to EMIT; otherwise repeat.
  - Column wrap is the shredder's responsibility.
- EMIT:
  - out_valid = 1, out_data = cur[row], out_last = (row == HEIGHT-1).
  - On out_ready, advance row. After the last handshake: done = 1 for one cycle, go to IDLE.
- sh_* outputs are don't-care outside COMPUTE; they are driven with the current-bank window and never X.
- Reset:
  - Registers go to IDLE, row = 0, cur_bank = 0, gen_count = 0, err_framing = 0.
  - Outputs go to in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, done = 0, busy = 0.
  - Bank contents are not cleared.
  - Reset overrides start and all handshakes in the same cycle.

## Timing
- start in cycle t: busy = 1 and in_ready = 1 from cycle t+1.
- in_ready and out_valid/out_data/out_last are combinational from state and registers only. There are no combinational paths from in_valid or out_ready.
- out_data and out_last stay stable while out_valid & !out_ready.
- Cycle count, excluding stall cycles:
  - LOAD: HEIGHT handshakes.
  - COMPUTE: exactly num_gens*HEIGHT cycles with no stalls.
  - EMIT: first out_valid in the cycle after the last compute row (or after the last load when num_gens = 0).
- done asserts in the cycle after the final EMIT handshake; busy drops in that same cycle.
- gen_count is monotonic within a run and holds its final value in IDLE until the next start.
- start is ignored in every cycle where busy = 1.

## Test plan
Bench uses WIDTH = 8, HEIGHT = 8, a behavioral toroidal shredder, and a golden Life model.
- Blinker: row 3 = 0x1C, others 0, num_gens = 1 -> rows 2,3,4 = 0x08, others 0. gen_count = 1; done pulses once, one cycle after the 8th beat. Same input with num_gens = 2 -> original frame.
- num_gens = 0, rows 0x01..0x80 -> output identical, out_last only on the 8th beat. Zero cycles with sh_* captured.
- Glider at top-left, num_gens = 32 -> output equals input (toroidal wrap). gen_count = 32; start-to-first-out_valid = 8 load + 256 compute cycles + 1.
- in_last on the 5th row of all-0xFF rows, num_gens = 0 -> err_framing = 1; emitted rows 5..7 = 0x00, rows 0..4 = 0xFF. Next accepted start clears err_framing.
- Backpressure: in_valid pattern 1,0,1,1 and out_ready toggling 1,0 -> no lost or duplicated rows; out_data stable during stalls; exactly 8 output beats. start pulsed mid-run is ignored.
- ARESET asserted during COMPUTE generation 3 -> next cycle busy = 0, in_ready = 0, out_valid = 0, gen_count = 0. A following run yields correct results.

Source files
------------

// File: rtl/conware_gen_ctrl.sv
// Generation sequencer for the Conway datapath: captures a frame into a ping-pong
// store, steps it through the external shredder array num_gens times, then streams it out.
module conware_gen_ctrl #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int GEN_W  = 16,
  parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic [GEN_W-1:0] num_gens,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] sh_above,
  output logic [WIDTH-1:0] sh_center,
  output logic [WIDTH-1:0] sh_below,
  input  logic [WIDTH-1:0] sh_next,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic             err_framing
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  logic [WIDTH-1:0] frame_q [2][HEIGHT];
  logic [WIDTH-1:0] frame_d [2][HEIGHT];

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic             cur_bank_q, cur_bank_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [GEN_W-1:0] num_gens_q, num_gens_d;
  logic             err_framing_q, err_framing_d;
  logic             done_q, done_d;

  logic [RW-1:0]    row_above, row_below;
  logic             row_is_last, in_hs, out_hs;

  // Toroidal row neighbours; with HEIGHT = 1 both collapse onto row 0.
  assign row_is_last = (row_q == LAST_ROW);
  assign row_above   = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
  assign row_below   = row_is_last ? '0 : row_q + 1'b1;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_valid ? frame_q[cur_bank_q][row_q] : '0;
  assign out_last  = out_valid && row_is_last;
  assign in_hs     = in_ready && in_valid;
  assign out_hs    = out_valid && out_ready;

  assign sh_above  = frame_q[cur_bank_q][row_above];
  assign sh_center = frame_q[cur_bank_q][row_q];
  assign sh_below  = frame_q[cur_bank_q][row_below];

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign gen_count   = gen_count_q;
  assign err_framing = err_framing_q;

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no branch below can infer a latch.
    state_d       = state_q;
    row_d         = row_q;
    cur_bank_d    = cur_bank_q;
    gen_count_d   = gen_count_q;
    num_gens_d    = num_gens_q;
    err_framing_d = err_framing_q;
    done_d        = 1'b0;
    frame_d       = frame_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          num_gens_d    = num_gens;
          row_d         = '0;
          gen_count_d   = '0;
          err_framing_d = 1'b0;
        end
      end

      S_LOAD: begin
        if (in_hs) begin
          frame_d[cur_bank_q][row_q] = in_data;
          if (row_is_last || in_last) begin
            // Early or missing in_last: flag it; a short frame is padded with dead rows.
            if (row_is_last != in_last) err_framing_d = 1'b1;
            for (int i = 0; i < HEIGHT; i++) begin
              if (i > int'(row_q)) frame_d[cur_bank_q][i] = '0;
            end
            row_d   = '0;
            state_d = (num_gens_q == '0) ? S_EMIT : S_COMPUTE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_COMPUTE: begin
        frame_d[~cur_bank_q][row_q] = sh_next;
        if (row_is_last) begin
          row_d       = '0;
          cur_bank_d  = ~cur_bank_q;
          gen_count_d = gen_count_q + 1'b1;
          if (gen_count_d == num_gens_q) state_d = S_EMIT;
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      S_EMIT: begin
        if (out_hs) begin
          if (row_is_last) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      cur_bank_q    <= 1'b0;
      gen_count_q   <= '0;
      num_gens_q    <= '0;
      err_framing_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cur_bank_q    <= cur_bank_d;
      gen_count_q   <= gen_count_d;
      num_gens_q    <= num_gens_d;
      err_framing_q <= err_framing_d;
      done_q        <= done_d;
    end
  end

  // NOTE: the frame store is deliberately not reset; reset only blocks writes in its cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESET) frame_q <= frame_d;
  end

endmodule

// File: tb/tb_conware_gen_ctrl.sv
// Self-checking bench for conware_gen_ctrl: 8x8 frames, behavioural toroidal shredder,
// golden whole-frame Life model and a per-cycle output compare process.
module tb_conware_gen_ctrl;

  localparam int W = 8;
  localparam int H = 8;
  localparam int G = 16;

  typedef logic [H-1:0][W-1:0] frame_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [G-1:0]  num_gens = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sh_above, sh_center, sh_below, sh_next;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
  logic          busy, done;
  logic [G-1:0]  gen_count;
  logic          err_framing;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Compare-process model state.
  bit     mon_en = 1'b0;
  frame_t exp_frame = '0;
  int     exp_row = 0;
  bit     done_due = 1'b0;
  int     beats = 0;

  conware_gen_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(G)) dut (
    .ACLK(aclk), .ARESET(areset), .start(start), .num_gens(num_gens),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sh_above(sh_above), .sh_center(sh_center), .sh_below(sh_below), .sh_next(sh_next),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .gen_count(gen_count), .err_framing(err_framing)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Shredder row rule with column wrap: one center row from its three-row window.
  function automatic logic [W-1:0] next_row(input logic [W-1:0] a, input logic [W-1:0] m,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    int cnt, cl, cr;
    r = '0;
    for (int c = 0; c < W; c++) begin
      cl  = (c + W - 1) % W;
      cr  = (c + 1) % W;
      cnt = int'(a[cl]) + int'(a[c]) + int'(a[cr]) + int'(m[cl]) + int'(m[cr])
          + int'(b[cl]) + int'(b[c]) + int'(b[cr]);
      r[c] = (cnt == 3) || (cnt == 2 && m[c]);
    end
    return r;
  endfunction

  always_comb sh_next = next_row(sh_above, sh_center, sh_below);

  // Golden model: one generation of the whole torus by direct neighbour counting.
  function automatic frame_t life_step(input frame_t f);
    frame_t n;
    int cnt;
    n = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) cnt += int'(f[(r + dr + H) % H][(c + dc + W) % W]);
          end
        end
        n[r][c] = (cnt == 3) || (cnt == 2 && f[r][c]);
      end
    end
    return n;
  endfunction

  // Expected emitted frame: rows after the in_last row are dead, then n generations.
  function automatic frame_t model_frame(input frame_t f, input int last_row, input int n);
    frame_t m;
    m = f;
    for (int r = 0; r < H; r++) if (r > last_row) m[r] = '0;
    for (int g = 0; g < n; g++) m = life_step(m);
    return m;
  endfunction

  // Per-cycle compare process.
  always @(negedge aclk) begin
    if (!areset && mon_en) begin
      check("done_pulse", done, done_due);
      done_due = 1'b0;
      if (!busy) check("idle_quiet", {in_ready, out_valid}, 2'b00);
      if (out_valid) begin
        check("out_data", out_data, exp_frame[exp_row]);
        check("out_last", out_last, exp_row == H - 1);
        if (out_ready) begin
          beats++;
          if (exp_row == H - 1) begin
            exp_row  = 0;
            done_due = 1'b1;
          end else begin
            exp_row++;
          end
        end
      end
    end
  end

  task automatic do_start(input int n);
    start    = 1'b1;
    num_gens = G'(n);
    @(posedge aclk); #1;
    start    = 1'b0;
  endtask

  // vmode: 0 always valid, 1 pattern 1,0,1,1, 2 random.
  task automatic do_load(input frame_t f, input int last_row, input int vmode, input bit poke);
    logic [3:0] pat;
    int r, k;
    bit hs;
    pat = 4'b1101;
    r = 0;
    k = 0;
    while (r <= last_row && k < 500) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[k % 4] : ($urandom_range(0, 3) != 0);
      in_data  = f[r];
      in_last  = (r == last_row);
      if (poke && k == 2) begin
        start    = 1'b1;
        num_gens = G'(7);
      end
      @(negedge aclk);
      hs = in_valid && in_ready;
      @(posedge aclk); #1;
      start = 1'b0;
      if (hs) r++;
      k++;
    end
    check("load_rows", r, last_row + 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
  endtask

  // rmode: 0 always ready, 1 toggle 1,0, 2 random.
  task automatic run_frame(input frame_t f, input int n, input int last_row,
                           input int vmode, input int rmode, input bit poke);
    int start_cyc, first_ov;
    bit seen_done;
    exp_frame = model_frame(f, last_row, n);
    exp_row   = 0;
    beats     = 0;
    done_due  = 1'b0;
    mon_en    = 1'b1;
    start_cyc = cyc;
    do_start(n);
    check("start_busy", busy, 1'b1);
    check("start_in_ready", in_ready, 1'b1);
    check("start_err_clear", err_framing, 1'b0);
    do_load(f, last_row, vmode, poke);
    first_ov  = -1;
    seen_done = 1'b0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (poke && c == 5) begin
        start    = 1'b1;
        num_gens = G'(n + 1);
      end
      @(negedge aclk);
      if (out_valid && first_ov < 0) first_ov = cyc - start_cyc;
      if (done) seen_done = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
    end
    out_ready = 1'b0;
    check("done_seen", seen_done, 1'b1);
    check("beat_count", beats, H);
    if (vmode == 0) check("latency", first_ov, (last_row + 1) + n * H + 1);
    check("gen_count", gen_count, n);
    check("busy_after", busy, 1'b0);
    check("err_framing", err_framing, last_row != H - 1);
    repeat (3) @(posedge aclk);
    #1;
    check("gen_count_hold", gen_count, n);
    check("beats_no_extra", beats, H);
  endtask

  initial begin
    frame_t blink, ramp, glider, ones, rnd, e;
    int n, last, tmo;

    // Reset state, with start held during reset to show it is overridden.
    start = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    start = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_gen_count", gen_count, 0);
    check("rst_err", err_framing, 1'b0);
    areset = 1'b0;
    @(posedge aclk); #1;
    check("idle_after_rst", busy, 1'b0);

    blink    = '0;
    blink[3] = 8'h1C;
    glider    = '0;
    glider[0] = 8'h02;
    glider[1] = 8'h04;
    glider[2] = 8'h07;
    ones = '1;
    for (int r = 0; r < H; r++) ramp[r] = 8'h01 << r;

    // Hand-computed pins on the model and the shredder rule.
    check("pin_shred_center", next_row(8'h00, 8'h1C, 8'h00), 8'h08);
    check("pin_shred_below", next_row(8'h1C, 8'h00, 8'h00), 8'h08);
    check("pin_blink_1", model_frame(blink, 7, 1), 64'h0000_0008_0808_0000);
    check("pin_blink_2", model_frame(blink, 7, 2), 64'h0000_0000_1C00_0000);
    check("pin_glider_32", model_frame(glider, 7, 32), 64'h0000_0000_0007_0402);
    check("pin_framing", model_frame(ones, 4, 0), 64'h0000_00FF_FFFF_FFFF);

    run_frame(blink, 1, 7, 0, 0, 1'b0);
    run_frame(blink, 2, 7, 0, 0, 1'b0);
    run_frame(ramp, 0, 7, 0, 0, 1'b0);
    run_frame(glider, 32, 7, 0, 0, 1'b0);
    run_frame(ones, 0, 4, 0, 0, 1'b0);

    // Backpressure on both sides with start pokes mid-run; also clears err_framing.
    for (int r = 0; r < H; r++) rnd[r] = W'($urandom);
    run_frame(rnd, 2, 7, 1, 1, 1'b1);

    // Reset in the middle of generation 3.
    mon_en = 1'b0;
    do_start(10);
    do_load(glider, 7, 0, 1'b0);
    tmo = 0;
    while (gen_count != 2 && tmo < 200) begin
      @(posedge aclk); #1;
      tmo++;
    end
    check("reach_gen3", gen_count, 2);
    repeat (3) @(posedge aclk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_gen_count", gen_count, 0);
    repeat (2) @(posedge aclk);
    #1;
    run_frame(glider, 4, 7, 0, 0, 1'b0);

    // Randomised runs: random frames, counts, early in_last, stalls on both sides.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < H; r++) rnd[r] = W'($urandom);
      n    = $urandom_range(0, 4);
      last = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 7;
      run_frame(rnd, n, last, 2, 2, t[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
